// File: rtl/snes_multi_snooper.sv
// Passive multi-port SNES controller snooper: synchronises latch/clk/data pins, deserialises
// each port's frame and publishes it with a valid pulse, flagging short, long and stalled frames.

module snes_snoop_port #(
  parameter int BITS           = 16,
  parameter int INVERT         = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_latch_rise,
  input  logic            i_latch_fall,
  input  logic            i_sclk,
  input  logic            i_sdata,
  output logic [BITS-1:0] o_state,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_err_short,
  output logic            o_err_long,
  output logic            o_err_timeout
);
  localparam int CW = $clog2(BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BITS);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic          INV      = (INVERT != 0);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // [0],[1] synchroniser, [2] edge-detect history
  logic [2:0]      r_clk_pipe;
  logic [1:0]      r_dat_pipe;
  logic [0:0]      r_st;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_timer;
  logic [BITS-1:0] r_shreg;
  logic            r_committed;
  logic            w_fall;
  logic            w_bit;

  assign w_fall = r_clk_pipe[2] & ~r_clk_pipe[1];
  assign w_bit  = r_dat_pipe[1] ^ INV;
  assign o_busy = (r_st == S_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_pipe <= 3'b111;
      r_dat_pipe <= '0;
    end else begin
      r_clk_pipe <= {r_clk_pipe[1:0], i_sclk};
      r_dat_pipe <= {r_dat_pipe[0], i_sdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st          <= S_IDLE;
      r_count       <= '0;
      r_timer       <= '0;
      r_shreg       <= '0;
      r_committed   <= 1'b0;
      o_state       <= '0;
      o_valid       <= 1'b0;
      o_err_short   <= 1'b0;
      o_err_long    <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      o_valid       <= 1'b0;
      o_err_short   <= 1'b0;
      o_err_long    <= 1'b0;
      o_err_timeout <= 1'b0;
      if (i_latch_rise) r_committed <= 1'b0;
      case (r_st)
        S_IDLE: begin
          if (i_latch_fall) begin
            r_st    <= S_SHIFT;
            r_count <= '0;
            r_timer <= '0;
            r_shreg <= '0;
          end else if (w_fall && r_committed) begin
            o_err_long <= 1'b1;
          end
        end
        default: begin
          if (r_count == CNT_FULL) begin
            o_state     <= r_shreg;
            o_valid     <= 1'b1;
            r_committed <= 1'b1;
            r_st        <= S_IDLE;
          end else if (w_fall) begin
            // shift in from the top so the first bit lands in bit 0 after BITS falls
            r_shreg <= {w_bit, r_shreg[BITS-1:1]};
            r_count <= r_count + 1'b1;
            r_timer <= '0;
            if (i_latch_rise && r_count != CNT_LAST) begin
              o_err_short <= 1'b1;
              r_st        <= S_IDLE;
            end
          end else if (i_latch_rise) begin
            o_err_short <= 1'b1;
            r_st        <= S_IDLE;
          end else if (r_timer == TMR_LAST) begin
            o_err_timeout <= 1'b1;
            r_st          <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

module snes_multi_snooper #(
  parameter int NUM_PORTS      = 2,
  parameter int BITS           = 16,
  parameter int INVERT         = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      snes_latch,
  input  logic [NUM_PORTS-1:0]      snes_clk,
  input  logic [NUM_PORTS-1:0]      snes_data,
  output logic [NUM_PORTS*BITS-1:0] state,
  output logic [NUM_PORTS-1:0]      valid,
  output logic [NUM_PORTS-1:0]      busy,
  output logic [NUM_PORTS-1:0]      err_short,
  output logic [NUM_PORTS-1:0]      err_long,
  output logic [NUM_PORTS-1:0]      err_timeout
);
  // shared latch: one synchroniser and edge detector broadcast to all ports
  logic [2:0] r_latch_pipe;
  logic       w_latch_rise;
  logic       w_latch_fall;

  always_ff @(posedge clk) begin
    if (reset) r_latch_pipe <= '0;
    else       r_latch_pipe <= {r_latch_pipe[1:0], snes_latch};
  end

  assign w_latch_rise = r_latch_pipe[1] & ~r_latch_pipe[2];
  assign w_latch_fall = ~r_latch_pipe[1] & r_latch_pipe[2];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    snes_snoop_port #(
      .BITS           (BITS),
      .INVERT         (INVERT),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_port (
      .clk           (clk),
      .reset         (reset),
      .i_latch_rise  (w_latch_rise),
      .i_latch_fall  (w_latch_fall),
      .i_sclk        (snes_clk[p]),
      .i_sdata       (snes_data[p]),
      .o_state       (state[p*BITS +: BITS]),
      .o_valid       (valid[p]),
      .o_busy        (busy[p]),
      .o_err_short   (err_short[p]),
      .o_err_long    (err_long[p]),
      .o_err_timeout (err_timeout[p])
    );
  end
endmodule

// File: tb/tb_snes_multi_snooper.sv
// Directed bench for snes_multi_snooper: bit-bangs latch/clk/data pins on two ports and checks
// published frames and error pulses against hand-computed values.

module tb_snes_multi_snooper;
  localparam int NP = 2;
  localparam int B  = 16;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            snes_latch = 1'b0;
  logic [NP-1:0]   snes_clk = '1;
  logic [NP-1:0]   snes_data = '1;
  logic [NP*B-1:0] state;
  logic [NP-1:0]   valid, busy, err_short, err_long, err_timeout;

  snes_multi_snooper #(.NUM_PORTS(NP), .BITS(B), .INVERT(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .snes_latch(snes_latch), .snes_clk(snes_clk),
    .snes_data(snes_data), .state(state), .valid(valid), .busy(busy),
    .err_short(err_short), .err_long(err_long), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int n_valid[NP], n_short[NP], n_long[NP], n_to[NP];
  int b_valid[NP], b_short[NP], b_long[NP], b_to[NP];
  int to_cyc = 0;
  int last_fall_cyc = 0;

  // pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NP; p++) begin
        if (valid[p])       n_valid[p]++;
        if (err_short[p])   n_short[p]++;
        if (err_long[p])    n_long[p]++;
        if (err_timeout[p]) begin n_to[p]++; to_cyc = cyc; end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    for (int p = 0; p < NP; p++) begin
      b_valid[p] = n_valid[p]; b_short[p] = n_short[p];
      b_long[p]  = n_long[p];  b_to[p]    = n_to[p];
    end
  endtask

  // latch pulse then nbits clock falls; optionally raise latch together with the last fall
  task automatic send_frame(input int nbits, input logic [31:0] d0, input logic [31:0] d1,
                            input bit collide);
    @(negedge clk);
    snes_latch = 1'b1; cycles(4);
    snes_latch = 1'b0; cycles(4);
    for (int i = 0; i < nbits; i++) begin
      snes_data[0] = d0[i];
      snes_data[1] = d1[i];
      cycles(3);
      snes_clk = '0;
      last_fall_cyc = cyc;
      if (collide && i == nbits - 1) snes_latch = 1'b1;
      cycles(3);
      snes_clk = '1;
      cycles(3);
    end
  endtask

  task automatic test_reset();
    cycles(3);
    checks++;
    if (state !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", state); end
    checks++;
    if ({valid, busy, err_short, err_long, err_timeout} !== '0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0", {valid, busy, err_short, err_long, err_timeout});
    end
    reset = 1'b0;
    cycles(5);
    checks++;
    if ({state, valid, busy, err_short, err_long, err_timeout} !== '0) begin
      failures++; $display("FAIL post_reset_quiet got=%h exp=0", {state, busy});
    end
  endtask

  task automatic test_nominal();
    snap();
    send_frame(16, 32'hFFFE, 32'h7FFF, 1'b0);
    cycles(8);
    checks++;
    if (state !== 32'h8000_0001) begin failures++; $display("FAIL nominal_state got=%h exp=80000001", state); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (n_valid[p] - b_valid[p] !== 1) begin
        failures++; $display("FAIL nominal_valid port=%0d got=%0d exp=1", p, n_valid[p] - b_valid[p]);
      end
      checks++;
      if (n_short[p] + n_long[p] + n_to[p] - b_short[p] - b_long[p] - b_to[p] !== 0) begin
        failures++; $display("FAIL nominal_errs port=%0d got=nonzero exp=0", p);
      end
    end
    checks++;
    if (busy !== 2'b00) begin failures++; $display("FAIL nominal_busy got=%b exp=00", busy); end
  endtask

  task automatic test_short();
    snap();
    send_frame(10, 32'h0000, 32'h0000, 1'b0);
    checks++;
    if (busy !== 2'b11) begin failures++; $display("FAIL short_busy got=%b exp=11", busy); end
    snes_latch = 1'b1;
    cycles(8);
    checks++;
    if (state !== 32'h8000_0001) begin failures++; $display("FAIL short_state got=%h exp=80000001", state); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (n_short[p] - b_short[p] !== 1 || n_valid[p] - b_valid[p] !== 0) begin
        failures++; $display("FAIL short_pulses port=%0d short=%0d valid=%0d exp=1/0", p,
                             n_short[p] - b_short[p], n_valid[p] - b_valid[p]);
      end
    end
  endtask

  task automatic test_long();
    snap();
    send_frame(17, 32'h0000_00FF, 32'h0001_F0F0, 1'b0);
    cycles(8);
    checks++;
    if (state !== 32'h0F0F_FF00) begin failures++; $display("FAIL long_state got=%h exp=0f0fff00", state); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (n_valid[p] - b_valid[p] !== 1 || n_long[p] - b_long[p] !== 1 || n_short[p] - b_short[p] !== 0) begin
        failures++; $display("FAIL long_pulses port=%0d valid=%0d long=%0d short=%0d exp=1/1/0", p,
                             n_valid[p] - b_valid[p], n_long[p] - b_long[p], n_short[p] - b_short[p]);
      end
    end
  endtask

  task automatic test_timeout();
    snap();
    send_frame(5, 32'h0, 32'h0, 1'b0);
    checks++;
    if (busy !== 2'b11) begin failures++; $display("FAIL timeout_busy_mid got=%b exp=11", busy); end
    cycles(TO + 16);
    // 3 cycles of pin-to-edge latency, then 64 stalled cycles
    checks++;
    if (to_cyc - last_fall_cyc !== TO + 3) begin
      failures++; $display("FAIL timeout_latency got=%0d exp=%0d", to_cyc - last_fall_cyc, TO + 3);
    end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (n_to[p] - b_to[p] !== 1 || n_valid[p] - b_valid[p] !== 0) begin
        failures++; $display("FAIL timeout_pulses port=%0d to=%0d valid=%0d exp=1/0", p,
                             n_to[p] - b_to[p], n_valid[p] - b_valid[p]);
      end
    end
    checks++;
    if (busy !== 2'b00 || state !== 32'h0F0F_FF00) begin
      failures++; $display("FAIL timeout_after busy=%b state=%h exp=00/0f0fff00", busy, state);
    end
  endtask

  task automatic test_collision();
    snap();
    send_frame(16, 32'h1234, 32'h00FF, 1'b1);
    cycles(8);
    checks++;
    if (state !== 32'hFF00_EDCB) begin failures++; $display("FAIL collide_state got=%h exp=ff00edcb", state); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (n_valid[p] - b_valid[p] !== 1 || n_short[p] - b_short[p] !== 0) begin
        failures++; $display("FAIL collide_pulses port=%0d valid=%0d short=%0d exp=1/0", p,
                             n_valid[p] - b_valid[p], n_short[p] - b_short[p]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8, 32'h00FF, 32'h00FF, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
    checks++;
    if (state !== '0 || busy !== 2'b00) begin
      failures++; $display("FAIL midreset_clear state=%h busy=%b exp=0/00", state, busy);
    end
    reset = 1'b0;
    cycles(2);
    snap();
    send_frame(16, 32'hA5A5, 32'hA5A5, 1'b0);
    cycles(8);
    checks++;
    if (state !== 32'h5A5A_5A5A) begin failures++; $display("FAIL midreset_state got=%h exp=5a5a5a5a", state); end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (n_valid[p] - b_valid[p] !== 1 ||
          n_short[p] + n_long[p] + n_to[p] - b_short[p] - b_long[p] - b_to[p] !== 0) begin
        failures++; $display("FAIL midreset_pulses port=%0d valid=%0d exp=1 errs=0", p, n_valid[p] - b_valid[p]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_timeout();
    test_collision();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
